intc_irq_sequencer: RTL
=======================

Name: intc_irq_sequencer

Overview:
- CPU-side controller for the interrupt controller (intc_top). It converts the intc IRQ/isr_addr level interface into a handshaked CPU interrupt request, latches the vector and generates the one-cycle IACK back to intc.
- Tracks in-service state, so there is no nesting. Enforces a post-service guard interval so that a stale IRQ is not retaken.
- Sits between intc_top and the core; provides a request watchdog and a served-interrupt counter for the AXI status registers.

Parameters:
- DATA_WIDTH, 32, width of the ISR address/vector.
- TIMEOUT_CYCLES, 1024, max cycles REQ may wait for cpu_take before abandoning.
- CNT_WIDTH, 16, width of the served_count counter.
- GUARD_CYCLES, 2, idle cycles after service end before irq is sampled again (≥1).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- irq  in  1  interrupt request level from intc_top.
- isr_addr  in  DATA_WIDTH  ISR address from intc_top; valid while irq=1.
- iack  out  1  interrupt acknowledge to intc_top; one-cycle pulse.
- cpu_int_en  in  1  CPU global interrupt enable.
- cpu_int  out  1  interrupt request to the CPU.
- cpu_vector  out  DATA_WIDTH  latched ISR address presented to the CPU.
- cpu_take  in  1  CPU accepts the interrupt; sampled only in REQ.
- cpu_iret  in  1  CPU return-from-interrupt; sampled only in SERVICE.
- in_service  out  1  high from ACK through SERVICE.
- timeout_err  out  1  sticky; set on REQ timeout.
- err_clr  in  1  clears timeout_err.
- served_count  out  CNT_WIDTH  saturating count of acknowledged interrupts.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low. All outputs are registered.
- Reset values: state=IDLE; cpu_int=0; iack=0; in_service=0; cpu_vector=0; timeout_err=0; served_count=0; the timeout and guard counters are 0.
- Reset asserted mid-operation: reset wins from any state. No IACK is issued, and in_service drops next edge.
- IDLE:
  - When irq=1 and cpu_int_en=1: go to REQ and latch cpu_vector<=isr_addr on the same edge.
  - cpu_int rises on that edge, so latency is 1 cycle from irq to cpu_int.
- REQ (cpu_int=1), priority order:
  - cpu_take=1 -> ACK. Take wins even if irq or cpu_int_en drops in the same cycle, because the vector is already latched.
  - Otherwise, irq=0 or cpu_int_en=0 -> IDLE (request withdrawn) and cpu_int drops. No error, no count.
  - Otherwise, after TIMEOUT_CYCLES consecutive REQ cycles without take -> IDLE and timeout_err<=1.
  - The timeout counter resets on REQ entry.
- ACK:
  - iack=1 for exactly this one cycle; cpu_int=0; in_service=1.
  - served_count increments, saturating at all-ones.
  - Unconditionally -> SERVICE.
- SERVICE:
  - in_service=1.
  - irq and cpu_take are ignored (no nesting).
  - cpu_iret=1 -> GUARD.
  - cpu_iret in any other state is ignored.
- GUARD:
  - Lasts GUARD_CYCLES cycles with all outputs low (except the sticky ones), then -> IDLE.
  - irq is not sampled, which gives intc ≥GUARD_CYCLES+1 cycles after iack to update IRQ/isr_addr.
- cpu_vector: holds its value from latch until the next IDLE->REQ transition.
- timeout_err:
  - err_clr=1 clears it.
  - If a set and err_clr coincide, set wins.
- cpu_int: equals (state==REQ). in_service equals (state==ACK or SERVICE). iack equals (state==ACK).

Decomposition:
- Shared package intc_pkg:
  - state enum (IDLE, REQ, ACK, SERVICE, GUARD);
  - default TIMEOUT_CYCLES and GUARD_CYCLES constants;
  - DATA_WIDTH localparam shared with the intc wrapper.
- One natural sub-module, intc_sat_counter: parameterised saturating up-counter with clear. It is used for served_count and reused for the timeout and guard counters.

Test Plan:
1. Basic service:
   - Stimulus: irq=1, isr_addr=0x0000_0040, cpu_int_en=1; cpu_take on cycle 3; cpu_iret 5 cycles later.
   - Required response: cpu_int at cycle 1, cpu_vector=0x40, single iack pulse after take, in_service high until iret, served_count=1, irq ignored for 2 guard cycles.
2. Withdrawal:
   - Stimulus: irq rises and then falls before cpu_take.
   - Required response: cpu_int drops next edge, no iack, served_count unchanged, timeout_err=0.
3. Timeout:
   - Stimulus: TIMEOUT_CYCLES=8; irq held high, never take.
   - Required response: after 8 REQ cycles, cpu_int=0 and timeout_err=1. Next edge re-enters REQ. err_clr asserted together with a new timeout leaves timeout_err=1.
4. Back-to-back:
   - Stimulus: irq held high throughout, isr_addr changes 0x40->0x80 one cycle after iack.
   - Required response: second REQ only after GUARD_CYCLES, second cpu_vector=0x80, served_count=2.
5. Simultaneous events:
   - Stimulus: cpu_take and irq=0 in the same cycle -> required response: iack is issued.
   - Stimulus: cpu_take asserted during SERVICE -> required response: ignored.
   - Stimulus: cpu_int_en=0 in IDLE with irq=1 -> required response: no request.
6. Reset and saturation:
   - Stimulus: rst_n=0 during SERVICE -> required response: all outputs zero next edge, no iack.
   - Stimulus: CNT_WIDTH=2 with 5 services -> required response: served_count=3.

Source files
------------

// File: rtl/intc_pkg.sv
// -----------------------------------------------------------------------------
// intc_pkg
//   Shared definitions for the interrupt controller and its CPU-side sequencer.
//   Holds the sequencer state encoding, the default timing constants and the
//   ISR address width that the intc wrapper also uses.
//   No ports (package).
// -----------------------------------------------------------------------------
package intc_pkg;

   localparam int INTC_DATA_WIDTH    = 32;
   localparam int DEF_TIMEOUT_CYCLES = 1024;
   localparam int DEF_GUARD_CYCLES   = 2;
   localparam int DEF_CNT_WIDTH      = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_ACK,
      ST_SERVICE,
      ST_GUARD
   } seq_state_t;

endpackage

// File: rtl/intc_irq_sequencer_if.sv
// -----------------------------------------------------------------------------
// intc_irq_sequencer_if
//   Bundles the intc-facing and CPU-facing signals of the IRQ sequencer.
//   master : drives irq/isr_addr (intc side), cpu_int_en/cpu_take/cpu_iret
//            (CPU side) and err_clr (status register side); observes outputs.
//   slave  : the sequencer itself.
//   Signals:
//     irq, isr_addr      - level request and vector from intc_top
//     iack               - one-cycle acknowledge back to intc_top
//     cpu_int_en         - CPU global interrupt enable
//     cpu_int, cpu_vector- request and latched vector presented to the CPU
//     cpu_take, cpu_iret - CPU accept / return-from-interrupt
//     in_service         - high from ACK through SERVICE
//     timeout_err, err_clr - sticky REQ-timeout flag and its clear
//     served_count       - saturating count of acknowledged interrupts
// -----------------------------------------------------------------------------
interface intc_irq_sequencer_if
   import intc_pkg::*;
#(
   parameter int DATA_WIDTH = INTC_DATA_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
);
   logic                  irq;
   logic [DATA_WIDTH-1:0] isr_addr;
   logic                  iack;
   logic                  cpu_int_en;
   logic                  cpu_int;
   logic [DATA_WIDTH-1:0] cpu_vector;
   logic                  cpu_take;
   logic                  cpu_iret;
   logic                  in_service;
   logic                  timeout_err;
   logic                  err_clr;
   logic [CNT_WIDTH-1:0]  served_count;

   modport master (
      output irq, isr_addr, cpu_int_en, cpu_take, cpu_iret, err_clr,
      input  iack, cpu_int, cpu_vector, in_service, timeout_err, served_count
   );

   modport slave (
      input  irq, isr_addr, cpu_int_en, cpu_take, cpu_iret, err_clr,
      output iack, cpu_int, cpu_vector, in_service, timeout_err, served_count
   );
endinterface

// File: rtl/intc_sat_counter.sv
// -----------------------------------------------------------------------------
// intc_sat_counter
//   Up-counter that sticks at all-ones. Clear has priority over increment.
//   Ports:
//     clk     - rising-edge clock
//     rst_n   - synchronous active-low reset
//     i_clr   - synchronous clear to zero
//     i_inc   - count enable
//     o_count - current count
// -----------------------------------------------------------------------------
module intc_sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);
   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst_n || i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;
endmodule

// File: rtl/intc_irq_sequencer.sv
// -----------------------------------------------------------------------------
// intc_irq_sequencer
//   CPU-side controller for intc_top. Turns the intc irq/isr_addr level into a
//   handshaked CPU request, latches the vector, pulses iack for one cycle on
//   take, tracks in-service (no nesting), and enforces a guard interval after
//   iret so a stale irq is not retaken. Provides a REQ watchdog (sticky
//   timeout_err) and a saturating served-interrupt counter.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - synchronous active-low reset
//     bus   - slave side of intc_irq_sequencer_if (all other signals)
//   All outputs are registered.
// -----------------------------------------------------------------------------
module intc_irq_sequencer
   import intc_pkg::*;
#(
   parameter int DATA_WIDTH     = INTC_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
   parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES
) (
   input logic                  clk,
   input logic                  rst_n,
   intc_irq_sequencer_if.slave  bus
);
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GD_W = $clog2(GUARD_CYCLES + 1);

   seq_state_t            r_state;
   logic                  r_cpu_int;
   logic                  r_iack;
   logic                  r_in_service;
   logic                  r_timeout_err;
   logic [DATA_WIDTH-1:0] r_cpu_vector;

   logic [TO_W-1:0]       w_to_cnt;
   logic [GD_W-1:0]       w_gd_cnt;
   logic [CNT_WIDTH-1:0]  w_served;
   logic                  w_in_req;
   logic                  w_in_guard;
   logic                  w_to_fire;
   logic                  w_guard_done;

   assign w_in_req   = (r_state == ST_REQ);
   assign w_in_guard = (r_state == ST_GUARD);

   // Counters hold zero outside their state, so they restart on every entry
   // and the count equals (cycles already spent in the state) - 1 at the
   // deciding edge.
   intc_sat_counter #(.WIDTH(TO_W)) u_to_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (!w_in_req),
      .i_inc   (w_in_req),
      .o_count (w_to_cnt)
   );

   intc_sat_counter #(.WIDTH(GD_W)) u_gd_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (!w_in_guard),
      .i_inc   (w_in_guard),
      .o_count (w_gd_cnt)
   );

   intc_sat_counter #(.WIDTH(CNT_WIDTH)) u_served_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (1'b0),
      .i_inc   (r_state == ST_ACK),
      .o_count (w_served)
   );

   // Timeout only counts when neither take nor withdrawal applies this cycle.
   assign w_to_fire    = w_in_req && !bus.cpu_take && bus.irq && bus.cpu_int_en &&
                         (w_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign w_guard_done = (w_gd_cnt == GD_W'(GUARD_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_cpu_int     <= 1'b0;
         r_iack        <= 1'b0;
         r_in_service  <= 1'b0;
         r_timeout_err <= 1'b0;
         r_cpu_vector  <= '0;
      end else begin
         if (w_to_fire) begin
            r_timeout_err <= 1'b1;
         end else if (bus.err_clr) begin
            r_timeout_err <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (bus.irq && bus.cpu_int_en) begin
                  r_state      <= ST_REQ;
                  r_cpu_vector <= bus.isr_addr;
                  r_cpu_int    <= 1'b1;
               end
            end
            ST_REQ: begin
               if (bus.cpu_take) begin
                  r_state      <= ST_ACK;
                  r_cpu_int    <= 1'b0;
                  r_iack       <= 1'b1;
                  r_in_service <= 1'b1;
               end else if (!bus.irq || !bus.cpu_int_en || w_to_fire) begin
                  r_state   <= ST_IDLE;
                  r_cpu_int <= 1'b0;
               end
            end
            ST_ACK: begin
               r_state <= ST_SERVICE;
               r_iack  <= 1'b0;
            end
            ST_SERVICE: begin
               if (bus.cpu_iret) begin
                  r_state      <= ST_GUARD;
                  r_in_service <= 1'b0;
               end
            end
            ST_GUARD: begin
               if (w_guard_done) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_cpu_int    <= 1'b0;
               r_iack       <= 1'b0;
               r_in_service <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cpu_int      = r_cpu_int;
   assign bus.iack         = r_iack;
   assign bus.in_service   = r_in_service;
   assign bus.timeout_err  = r_timeout_err;
   assign bus.cpu_vector   = r_cpu_vector;
   assign bus.served_count = w_served;
endmodule
